// File: rtl/alu_mdu_control.sv
// ---------------------------------------------------------------------------
// alu_mdu_control
//
// Execute-stage ALU control decoder with an iterative RV32M multiply/divide
// unit. The 4-bit ALU Operation code is decoded combinationally as before.
// M-extension ops (ALUOp=10, Funct7=0000001) are accepted in IDLE and run as
// radix-2 shift-add multiply or restoring divide in BUSY. The finished
// result is then held in DONE until the pipeline consumes it.
//
// Configuration macro: ALU_MDU_DIV_EN
//   defined   - DIV/DIVU/REM/REMU are executed, with divide-by-zero and
//               signed-overflow handled in a single cycle.
//   undefined - no divider datapath. Funct3 1xx M ops complete after one
//               edge with result=0 and illegal_op=1.
//
// Ports
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   ALUOp           : 00 mem, 01 branch, 10 R/I-type
//   Funct7, Funct3  : instruction function fields
//   in_valid        : execute stage holds a valid instruction
//   op_a, op_b      : rs1 / rs2 values (latched when an M op is accepted)
//   out_ready       : pipeline consumes the M result this cycle
//   Operation       : combinational ALU operation code
//   is_mdu          : combinational, instruction is an M op
//   in_ready        : unit is idle and can accept
//   stall           : hold the pipeline while an M op is in flight
//   out_valid       : result holds a finished M result
//   result          : registered M result
//   illegal_op      : registered, an excluded op was accepted
// ---------------------------------------------------------------------------
module alu_mdu_control #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             out_ready,
  output logic [3:0]       Operation,
  output logic             is_mdu,
  output logic             in_ready,
  output logic             stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             illegal_op
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_q;       // latched Funct3
  logic               res_neg;    // product / quotient must be negated
  logic [WIDTH-1:0]   opnd_q;     // |multiplicand| or |divisor|
  // Multiply: {partial product high, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits / quotient bits}.
  logic [2*WIDTH-1:0] prod;

  // ------------------------------------------------------------------------
  // ALU operation decode
  // ------------------------------------------------------------------------
  assign is_mdu = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    Operation = 4'b0000;
    case (ALUOp)
      2'b00: Operation = 4'b0010;
      2'b01: begin
        case (Funct3)
          3'b000:  Operation = 4'b1010;
          3'b001:  Operation = 4'b1011;
          3'b100:  Operation = 4'b1101;
          default: Operation = 4'b0000;
        endcase
      end
      2'b10: begin
        if (is_mdu) begin
          Operation = 4'b0010;  // ALU result is unused for M ops
        end else begin
          // Codes valid for any Funct7; refined below for the base encodings.
          case (Funct3)
            3'b000:  Operation = 4'b0010;
            3'b011:  Operation = 4'b1100;
            3'b010:  Operation = 4'b0101;
            default: Operation = 4'b1001;
          endcase
          if (Funct7 == 7'b0000000) begin
            if (Funct3 == 3'b111)      Operation = 4'b0000;
            else if (Funct3 == 3'b110) Operation = 4'b0001;
            else if (Funct3 == 3'b100) Operation = 4'b0110;
            else if (Funct3 == 3'b001) Operation = 4'b0100;
            else if (Funct3 == 3'b101) Operation = 4'b0111;
          end else if (Funct7 == 7'b0100000) begin
            if (Funct3 == 3'b000)      Operation = 4'b0011;
            else if (Funct3 == 3'b101) Operation = 4'b1000;
          end
        end
      end
      default: Operation = 4'b0000;
    endcase
  end

  // ------------------------------------------------------------------------
  // Accept-time operand conditioning
  // ------------------------------------------------------------------------
  logic             accept;
  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             fast;
  logic             fast_illegal;
  logic [WIDTH-1:0] fast_res;

  assign accept   = (state == S_IDLE) && in_valid && is_mdu;

  // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as
  // signed. MUL is sign-agnostic in its low half, so it runs unsigned.
  assign a_signed = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                    (Funct3 == 3'b100) || (Funct3 == 3'b110);
  assign b_signed = (Funct3 == 3'b001) || (Funct3 == 3'b100) ||
                    (Funct3 == 3'b110);
  assign a_neg    = a_signed & op_a[WIDTH-1];
  assign b_neg    = b_signed & op_b[WIDTH-1];
  // The most-negative value maps onto itself, which read unsigned is the
  // correct magnitude.
  assign mag_a    = a_neg ? -op_a : op_a;
  assign mag_b    = b_neg ? -op_b : op_b;

`ifdef ALU_MDU_DIV_EN
  logic div_zero, div_ovf;
  logic rem_neg;  // remainder takes the dividend's sign

  assign div_zero = Funct3[2] && (op_b == '0);
  assign div_ovf  = ((Funct3 == 3'b100) || (Funct3 == 3'b110)) &&
                    (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);
  assign fast         = div_zero || div_ovf;
  assign fast_illegal = 1'b0;

  always_comb begin
    fast_res = '0;
    if (div_zero)     fast_res = Funct3[1] ? op_a : '1;
    else if (div_ovf) fast_res = Funct3[1] ? '0 : op_a;
  end
`else
  assign fast         = Funct3[2];
  assign fast_illegal = Funct3[2];
  assign fast_res     = '0;
`endif

  // ------------------------------------------------------------------------
  // Iteration step and final sign fix-up
  // ------------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] step_nx;
  logic [2*WIDTH-1:0] mul_full;
  logic [WIDTH-1:0]   mul_res;
  logic [WIDTH-1:0]   fix_res;

  assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} +
                    (prod[0] ? {1'b0, opnd_q} : '0);
  assign mul_full = res_neg ? -prod : prod;
  assign mul_res  = (op_q[1:0] == 2'b00) ? mul_full[WIDTH-1:0]
                                         : mul_full[2*WIDTH-1:WIDTH];

`ifdef ALU_MDU_DIV_EN
  logic [WIDTH:0]   div_shift, div_diff;
  logic [WIDTH-1:0] quo_res, rem_res;

  assign div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  // A negative trial difference restores the shifted remainder.
  assign step_nx   = op_q[2]
                   ? (div_diff[WIDTH]
                      ? {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                      : {div_diff[WIDTH-1:0],  prod[WIDTH-2:0], 1'b1})
                   : {mul_sum, prod[WIDTH-1:1]};
  assign quo_res   = res_neg ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
  assign rem_res   = rem_neg ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
  assign fix_res   = op_q[2] ? (op_q[1] ? rem_res : quo_res) : mul_res;
`else
  assign step_nx   = {mul_sum, prod[WIDTH-1:1]};
  assign fix_res   = mul_res;
`endif

  // ------------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge.
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept)      state_nx = fast ? S_DONE : S_BUSY;
      S_BUSY: if (cnt == '0)   state_nx = S_DONE;
      S_DONE: if (out_ready)   state_nx = S_IDLE;
      default:                 state_nx = S_IDLE;
    endcase
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign stall     = in_valid && is_mdu && (state != S_DONE);

  // Counter and visible outputs. BUSY runs WIDTH steps (cnt WIDTH..1), then
  // one more edge at cnt==0 applies the sign fix-up and enters DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      result     <= '0;
      illegal_op <= 1'b0;
    end else if (accept) begin
      illegal_op <= fast_illegal;
      if (fast) result <= fast_res;
      else      cnt    <= CNT_W'(WIDTH);
    end else if (state == S_BUSY) begin
      if (cnt == '0) result <= fix_res;
      else           cnt    <= cnt - CNT_W'(1);
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded on
  // accept before being read, and reset only needs to abort the FSM.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= Funct3;
      res_neg <= a_neg ^ b_neg;
      prod    <= {{WIDTH{1'b0}}, (Funct3[2] ? mag_a : mag_b)};
      opnd_q  <= Funct3[2] ? mag_b : mag_a;
    end else if ((state == S_BUSY) && (cnt != '0)) begin
      prod    <= step_nx;
    end
  end

`ifdef ALU_MDU_DIV_EN
  always_ff @(posedge clk) begin
    if (accept) rem_neg <= a_neg;
  end
`endif

endmodule
